// File: rtl/imem_responder.sv
// Instruction-memory responder: in-order fetch responses after a fixed read pipeline,
// with a side loader port, an occupancy-limited request handshake and a redirect flush.
module imem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [31:0]                    req_addr,
  input  logic                           flush,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [31:0]                    rsp_instr,
  output logic [31:0]                    rsp_pc,
  output logic                           rsp_err,
  input  logic                           ld_en,
  input  logic [$clog2(DEPTH_WORDS)-1:0] ld_addr,
  input  logic [31:0]                    ld_data
);

  localparam int          AW  = $clog2(DEPTH_WORDS);
  localparam int          CAP = LATENCY + 1;
  localparam int          PW  = $clog2(CAP);
  localparam int          CW  = $clog2(CAP + 1);
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0]   mem_q [DEPTH_WORDS];

  logic          accept;
  logic          err_p0;
  logic [31:0]   instr_p0;

  logic          vld_q   [LATENCY];
  logic [31:0]   instr_q [LATENCY];
  logic [31:0]   pc_q    [LATENCY];
  logic          err_q   [LATENCY];

  logic [31:0]   fifo_instr_q [CAP];
  logic [31:0]   fifo_pc_q    [CAP];
  logic          fifo_err_q   [CAP];

  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d, occ_q, occ_d;
  logic          push, pop;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(CAP - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (ld_en) mem_q[ld_addr] <= ld_data;
  end

  // Accept stage: the array is read before this edge's loader write lands.
  assign req_ready = (occ_q < CW'(CAP));
  assign accept    = req_valid && req_ready;
  assign err_p0    = (|req_addr[1:0]) || (|req_addr[31:AW+2]);
  assign instr_p0  = err_p0 ? NOP : mem_q[req_addr[AW+1:2]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < LATENCY; i++) vld_q[i] <= 1'b0;
    end else begin
      vld_q[0] <= accept;
      for (int i = 1; i < LATENCY; i++) vld_q[i] <= flush ? 1'b0 : vld_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    instr_q[0] <= instr_p0;
    pc_q[0]    <= req_addr;
    err_q[0]   <= err_p0;
    for (int i = 1; i < LATENCY; i++) begin
      instr_q[i] <= instr_q[i-1];
      pc_q[i]    <= pc_q[i-1];
      err_q[i]   <= err_q[i-1];
    end
  end

  // Response FIFO: occupancy never exceeds CAP, so a push always finds a free slot.
  assign push      = vld_q[LATENCY-1] && !flush;
  assign rsp_valid = (cnt_q != '0);
  assign pop       = rsp_valid && rsp_ready;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    occ_d = occ_q;
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
      occ_d = accept ? CW'(1) : '0;
    end else begin
      if (push) wr_d = ptr_next(wr_q);
      if (pop)  rd_d = ptr_next(rd_q);
      cnt_d = cnt_q + CW'(push) - CW'(pop);
      occ_d = occ_q + CW'(accept) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      occ_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      occ_q <= occ_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_instr_q[wr_q] <= instr_q[LATENCY-1];
      fifo_pc_q[wr_q]    <= pc_q[LATENCY-1];
      fifo_err_q[wr_q]   <= err_q[LATENCY-1];
    end
  end

  assign rsp_instr = rsp_valid ? fifo_instr_q[rd_q] : '0;
  assign rsp_pc    = rsp_valid ? fifo_pc_q[rd_q]    : '0;
  assign rsp_err   = rsp_valid && fifo_err_q[rd_q];

endmodule
